alu_addsub_seq: RTL and testbench
=================================

# alu_addsub_seq

Parametrised, multi-cycle Y86 integer ALU that evaluates `addq`, `subq`, `andq` and `xorq` on WIDTH-bit signed operands, CHUNK bits per clock, with a carry register linking chunks. It generalises the execute-stage combinational 64-bit subtractor to all four Y86 ALU ops, selectable datapath width and slice size, and Y86 condition-code generation (ZF/SF/OF). It sits in the execute stage behind a valid/ready handshake, so the pipeline can trade ALU area for latency.

## Interface
- WIDTH, 64: operand and result width; must be a multiple of CHUNK.
- CHUNK, 16: bits processed per cycle. NCHUNK = WIDTH/CHUNK. CHUNK = WIDTH gives a one-cycle ALU.
- clk  in  1  rising-edge clock. The block uses one clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  WIDTH  operand A (Y86 valB).
- in_b  in  WIDTH  operand B (Y86 valA).
- in_op  in  2  0 = ADD (A+B), 1 = SUB (A−B), 2 = AND, 3 = XOR.
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- out_result  out  WIDTH  result.
- out_zf, out_sf, out_of  out  1 each  zero, sign, and signed-overflow flags.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: chunk counter k from 0 to NCHUNK−1.
  - DONE: out_valid=1.
- IDLE → BUSY on in_valid && in_ready:
  - Latch in_a, in_b, in_op.
  - Set k=0.
  - Set carry = 1 for SUB, 0 otherwise.
  - Clear the result register.
- BUSY: each cycle computes slice [k*CHUNK +: CHUNK].
  - ADD: a + b + carry.
  - SUB: a + ~b + carry (two's complement, carry initialised to 1).
  - AND/XOR: bitwise; carry is unused.
  - Write the slice into the result register and update carry with the slice carry-out.
  - k increments each cycle.
  - When k = NCHUNK−1, the slice is written, the flags are computed, and the state moves to DONE.
- Flags:
  - ZF = (result == 0).
  - SF = result[WIDTH−1].
  - OF for ADD: carry into MSB XOR carry out of MSB.
  - OF for SUB: the same, computed with ~b.
  - OF = 0 for AND and XOR.
  - Carry out of the MSB is discarded; result wraps modulo 2^WIDTH.
- DONE: result and flags are held stable while out_valid=1 && out_ready=0. On out_ready, move to IDLE.
- Inputs are ignored outside IDLE. in_a, in_b and in_op may change freely after acceptance.
- Signed interpretation affects only OF and SF. Result bits are identical for signed and unsigned operands.

## Timing
- Reset (rst high at a rising edge), on the following cycle:
  - state = IDLE, in_ready=1.
  - out_valid=0, out_result=0, out_zf=0, out_sf=0, out_of=0.
  - carry=0, k=0.
- While rst is high, in_valid is ignored.
- Reset mid-BUSY or mid-DONE aborts the operation with no output handshake. The in-flight result is lost.
- Latency:
  - Accept at edge E0.
  - out_valid rises after edge E0+NCHUNK: 4 cycles for 64/16, 1 cycle for CHUNK=WIDTH.
- Throughput:
  - Output handshake at edge Ed → IDLE after Ed; next accept at Ed+1 at the earliest.
  - Minimum interval is NCHUNK+2 cycles per op.
- in_ready and out_valid are registered state decodes. Neither depends combinationally on in_valid or out_ready.
- in_ready and out_valid are never both high.

## Test plan
- ADD carry across chunk boundary, 64/16: A=0x0000_0000_0000_FFFF, B=1 → result 0x0000_0000_0001_0000, ZF=0, SF=0, OF=0, out_valid exactly 4 cycles after accept.
- SUB wrap and sign: A=0, B=1 → result 0xFFFF_FFFF_FFFF_FFFF, SF=1, OF=0, ZF=0. A=B=0x1234 → result 0, ZF=1.
- Overflow:
  - ADD 0x7FFF_FFFF_FFFF_FFFF+1 → 0x8000_0000_0000_0000, OF=1, SF=1.
  - SUB 0x8000_0000_0000_0000−1 → 0x7FFF_FFFF_FFFF_FFFF, OF=1, SF=0.
- Logic ops: A=0xF0F0…F0, B=0xFF00…00. AND → 0xF000…00, XOR → 0x0FF0…F0 pattern, OF=0 for both. AND A=0x0F, B=0xF0 → 0, ZF=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0, and a pulse on in_valid is not accepted.
  - Separately, assert rst at k=2 → next cycle IDLE, out_valid=0, out_result=0.
- Parameter sweep: CHUNK ∈ {1, 8, 64} at WIDTH=64 and WIDTH=32/CHUNK=16. Random ops checked against a reference model; latency = WIDTH/CHUNK.

Source files
------------

// File: rtl/alu_addsub_seq.sv
// Multi-cycle Y86 ALU (addq/subq/andq/xorq): walks the operands CHUNK bits per
// clock with a carry register between slices and produces ZF/SF/OF at the end.
module alu_addsub_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic [1:0]       dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid is never withdrawn before ready, and neither ready nor
  // valid depends combinationally on the opposite side's signal.

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [KW-1:0]      k_q, k_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zf_q, zf_d;
  logic               sf_q, sf_d;
  logic               of_q, of_d;

  logic [IW-1:0]      base;
  logic [CHUNK-1:0]   a_sl;
  logic [CHUNK-1:0]   b_raw;
  logic [CHUNK-1:0]   b_sl;
  logic [CHUNK:0]     sum;
  logic [CHUNK-1:0]   slice_res;
  logic               arith;
  logic               c_msb_in;
  logic               slice_ovf;

  // SUB is A + ~B + 1: the +1 enters through the carry register preset at accept.
  always_comb begin
    base      = IW'(int'(k_q) * CHUNK);
    a_sl      = a_q[base +: CHUNK];
    b_raw     = b_q[base +: CHUNK];
    b_sl      = (op_q == OP_SUB) ? ~b_raw : b_raw;
    sum       = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    c_msb_in  = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum[CHUNK-1];
    slice_ovf = arith && (c_msb_in ^ sum[CHUNK]);
    case (op_q)
      OP_AND:  slice_res = a_sl & b_raw;
      OP_XOR:  slice_res = a_sl ^ b_raw;
      default: slice_res = sum[CHUNK-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    k_d      = k_q;
    carry_d  = carry_q;
    result_d = result_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          op_d     = in_op;
          k_d      = '0;
          carry_d  = (in_op == OP_SUB);
          result_d = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        result_d[base +: CHUNK] = slice_res;
        carry_d = sum[CHUNK];
        k_d     = k_q + KW'(1);
        // Flags only make sense once the top slice (holding the MSB) is in.
        if (k_q == K_LAST) begin
          k_d     = '0;
          zf_d    = (result_d == '0);
          sf_d    = result_d[WIDTH-1];
          of_d    = slice_ovf;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      k_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_zf     = zf_q;
  assign out_sf     = sf_q;
  assign out_of     = of_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: directed Y86 cases on a 64/16 instance, then
// random ops on five width/chunk configurations against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_addsub_seq;
  localparam int NI = 5;

  function automatic int ws(int g);
    return (g == 4) ? 32 : 64;
  endfunction

  function automatic int cs(int g);
    case (g)
      0:       return 16;
      1:       return 1;
      2:       return 8;
      3:       return 64;
      default: return 16;
    endcase
  endfunction

  logic              clk;
  logic              rst;
  logic [NI-1:0]     in_valid_v;
  logic [NI-1:0]     out_ready_v;
  logic [63:0]       in_a;
  logic [63:0]       in_b;
  logic [1:0]        in_op;
  wire  [NI-1:0]     in_ready_v;
  wire  [NI-1:0]     out_valid_v;
  wire  [NI-1:0]     zf_v;
  wire  [NI-1:0]     sf_v;
  wire  [NI-1:0]     of_v;
  wire  [63:0]       res_v [NI];
  wire  [1:0]        dbg_v [NI];

  int n_chk;
  int n_fail;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = ws(g);
    wire [W-1:0] r;
    alu_addsub_seq #(.WIDTH(W), .CHUNK(cs(g))) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
      .in_a(in_a[W-1:0]), .in_b(in_b[W-1:0]), .in_op(in_op),
      .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]),
      .out_result(r), .out_zf(zf_v[g]), .out_sf(sf_v[g]), .out_of(of_v[g]),
      .dbg_state(dbg_v[g])
    );
    assign res_v[g] = 64'(r);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {zf, sf, of, result} from plain modular arithmetic.
  function automatic logic [66:0] ref_model(int w, logic [63:0] a, logic [63:0] b, logic [1:0] op);
    logic [63:0] m, r;
    logic sa, sb, sr, ov;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a & m;
    b = b & m;
    case (op)
      2'd0:    r = (a + b) & m;
      2'd1:    r = (a - b) & m;
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    sa = a[w-1];
    sb = b[w-1];
    sr = r[w-1];
    if (op == 2'd0)      ov = (sa == sb) && (sr != sa);
    else if (op == 2'd1) ov = (sa != sb) && (sr != sa);
    else                 ov = 1'b0;
    return {(r == 64'd0), sr, ov, r};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(int g, logic [63:0] a, logic [63:0] b, logic [1:0] op);
    chk("accept_ready", 64'(in_ready_v[g]), 64'd1);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid_v[g] = 1'b1;
    tick();
    in_valid_v[g] = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(int g, output int lat);
    lat = 0;
    while (out_valid_v[g] !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic take(int g);
    out_ready_v[g] = 1'b1;
    tick();
    out_ready_v[g] = 1'b0;
    chk("post_take_out_valid", 64'(out_valid_v[g]), 64'd0);
    chk("post_take_in_ready", 64'(in_ready_v[g]), 64'd1);
  endtask

  task automatic chk_out(int g, string tag, logic [66:0] exp);
    chk({tag, "_result"}, res_v[g], exp[63:0]);
    chk({tag, "_zf"}, 64'(zf_v[g]), 64'(exp[66]));
    chk({tag, "_sf"}, 64'(sf_v[g]), 64'(exp[65]));
    chk({tag, "_of"}, 64'(of_v[g]), 64'(exp[64]));
  endtask

  task automatic directed(string tag, logic [63:0] a, logic [63:0] b, logic [1:0] op,
                          logic [63:0] r, logic zf, logic sf, logic ov);
    int lat;
    start_op(0, a, b, op);
    wait_done(0, lat);
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk_out(0, tag, {zf, sf, ov, r});
    take(0);
  endtask

  initial begin
    int lat;
    logic [63:0] a, b;
    logic [1:0]  op;
    logic [66:0] exp;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid_v = '1;
    out_ready_v = '0;
    in_a = 64'hDEAD_BEEF_0000_0001;
    in_b = 64'h1;
    in_op = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    in_valid_v = '0;
    for (int g = 0; g < NI; g++) begin
      chk("reset_in_ready", 64'(in_ready_v[g]), 64'd1);
      chk("reset_out_valid", 64'(out_valid_v[g]), 64'd0);
      chk_out(g, "reset", 67'd0);
    end

    directed("add_carry", 64'h0000_0000_0000_FFFF, 64'd1, 2'd0, 64'h0000_0000_0001_0000, 0, 0, 0);
    directed("sub_wrap", 64'd0, 64'd1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
    directed("sub_zero", 64'h1234, 64'h1234, 2'd1, 64'd0, 1, 0, 0);
    directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 64'h8000_0000_0000_0000, 0, 1, 1);
    directed("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1);
    directed("and_pat", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 2'd2, 64'hF000_F000_F000_F000, 0, 1, 0);
    directed("xor_pat", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 2'd3, 64'h0FF0_0FF0_0FF0_0FF0, 0, 0, 0);
    directed("and_zero", 64'h0F, 64'hF0, 2'd2, 64'd0, 1, 0, 0);

    // Backpressure: DONE held for 5 cycles with an in_valid pulse that must be ignored.
    start_op(0, 64'd5, 64'd3, 2'd1);
    wait_done(0, lat);
    chk("bp_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      chk_out(0, "bp_hold", {1'b0, 1'b0, 1'b0, 64'd2});
      chk("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
      chk("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
      in_valid_v[0] = (i == 2);
      in_a = 64'd100;
      in_b = 64'd100;
      in_op = 2'd0;
      tick();
    end
    in_valid_v[0] = 1'b0;
    take(0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_accept_in_ready", 64'(in_ready_v[0]), 64'd1);
      chk("bp_no_accept_out_valid", 64'(out_valid_v[0]), 64'd0);
      tick();
    end

    // Reset while the third slice is being computed.
    start_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd0);
    chk("busy_in_ready", 64'(in_ready_v[0]), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("midrst_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk_out(0, "midrst", 67'd0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_stays_idle", 64'(out_valid_v[0]), 64'd0);
      tick();
    end

    // Random sweep across all configurations.
    for (int g = 0; g < NI; g++) begin
      for (int n = 0; n < 25; n++) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0: b = a;
          1: a = (ws(g) == 64) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF;
          2: a = (ws(g) == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
          default: ;
        endcase
        exp = ref_model(ws(g), a, b, op);
        start_op(g, a, b, op);
        wait_done(g, lat);
        chk("rand_latency", 64'(lat), 64'(ws(g) / cs(g)));
        chk_out(g, "rand", exp);
        take(g);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
